// File: rtl/symbol_pkg.sv
// Shared sizing constants and types for the symbol window buffer.
package symbol_pkg;
  localparam int NUM_SYMBOLS  = 10;
  localparam int SYMBOL_WIDTH = 5;
  localparam int IN_SYMBOLS   = 5;
  localparam int SHIFT_WIDTH  = 3;
  localparam int MAX_TAKE     = 4;
  localparam int COUNT_W      = 4;

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;
  typedef logic [COUNT_W-1:0]      count_t;
endpackage

// File: rtl/shift_right.sv
// Combinational symbol-granular right shift; vacated top slots take the fill value.
module shift_right #(
  parameter int NUM       = 10,
  parameter int WIDTH     = 5,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 4
) (
  input  logic [NUM*WIDTH-1:0] in,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [WIDTH-1:0]     fill,
  output logic [NUM*WIDTH-1:0] out,
  output logic                 out_valid
);
  // Extended source covers every encodable shift so indexing never leaves the array.
  localparam int EXT   = NUM + 2**SHIFT_W;
  localparam int IDX_W = $clog2(EXT);

  logic [WIDTH-1:0] ext [EXT];

  for (genvar k = 0; k < EXT; k++) begin : g_ext
    if (k < NUM) begin : g_src
      assign ext[k] = in[k*WIDTH +: WIDTH];
    end else begin : g_fill
      assign ext[k] = fill;
    end
  end

  for (genvar j = 0; j < NUM; j++) begin : g_out
    assign out[j*WIDTH +: WIDTH] = ext[IDX_W'(j) + IDX_W'(shift)];
  end

  assign out_valid = (shift <= SHIFT_W'(MAX_SHIFT));
endmodule

// File: rtl/symbol_window_buffer.sv
// Sliding symbol window: full-beat appends at the top of the valid region, takes from the bottom.
module symbol_window_buffer
  import symbol_pkg::*;
#(
  parameter int NUM_SYMBOLS  = symbol_pkg::NUM_SYMBOLS,
  parameter int SYMBOL_WIDTH = symbol_pkg::SYMBOL_WIDTH,
  parameter int IN_SYMBOLS   = symbol_pkg::IN_SYMBOLS,
  parameter int SHIFT_WIDTH  = symbol_pkg::SHIFT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_SYMBOLS*SYMBOL_WIDTH-1:0] in_data,
  input  logic                              take_valid,
  input  logic [SHIFT_WIDTH-1:0]            take,
  output logic                              take_ready,
  input  logic [SYMBOL_WIDTH-1:0]           fill,
  output logic [NUM_SYMBOLS*SYMBOL_WIDTH-1:0] window,
  output logic [3:0]                        count,
  output logic                              bad_take
);
  localparam int WIN_W = NUM_SYMBOLS * SYMBOL_WIDTH;

  logic [WIN_W-1:0]        shifted;
  logic [WIN_W-1:0]        base_win;
  logic [WIN_W-1:0]        window_next;
  logic                    shift_valid;
  logic                    take_ok;
  logic                    push_acc;
  count_t                  take_acc;
  count_t                  base;
  count_t                  count_next;
  logic [SYMBOL_WIDTH-1:0] beat [IN_SYMBOLS];

  shift_right #(
    .NUM       (NUM_SYMBOLS),
    .WIDTH     (SYMBOL_WIDTH),
    .SHIFT_W   (SHIFT_WIDTH),
    .MAX_SHIFT (MAX_TAKE)
  ) u_shift (
    .in        (window),
    .shift     (take),
    .fill      (fill),
    .out       (shifted),
    .out_valid (shift_valid)
  );

  for (genvar i = 0; i < IN_SYMBOLS; i++) begin : g_beat
    assign beat[i] = in_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  end

  // Readiness depends only on registered count so upstream sees no take->ready path.
  assign in_ready   = (count <= COUNT_W'(NUM_SYMBOLS - IN_SYMBOLS));
  assign take_ok    = take_valid && shift_valid && (COUNT_W'(take) <= count);
  assign take_ready = take_ok;
  assign push_acc   = in_valid && in_ready;
  assign take_acc   = take_ok ? COUNT_W'(take) : '0;
  assign base       = count - take_acc;
  assign base_win   = take_ok ? shifted : window;
  assign count_next = count - take_acc + (push_acc ? COUNT_W'(IN_SYMBOLS) : '0);

  // Append lands just above the symbols that survive this cycle's take.
  for (genvar j = 0; j < NUM_SYMBOLS; j++) begin : g_slot
    logic [SYMBOL_WIDTH-1:0] slot;
    always_comb begin
      slot = base_win[j*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      if (push_acc) begin
        for (int i = 0; i < IN_SYMBOLS; i++) begin
          if (i <= j && base == COUNT_W'(j - i)) slot = beat[i];
        end
      end
    end
    assign window_next[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] = slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window   <= '0;
      count    <= '0;
      bad_take <= 1'b0;
    end else begin
      window   <= window_next;
      count    <= count_next;
      bad_take <= take_valid && !take_ok;
    end
  end
endmodule
